// File: rtl/beamform_pkg.sv
// Shared types and constants for the four-mic delay-and-sum beamformer.
// Holds the mic count, delay input width, FSM state type and the sample type.
package beamform_pkg;

    localparam int NUM_MICS = 4;
    localparam int DELAY_W  = 8;
    localparam int SAMPLE_W = 16;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RUN
    } bf_state_t;

endpackage

// File: rtl/mic_delay_line.sv
// Per-mic ring buffer with a delayed tap.
// The tap is read before the write, so d=0 must bypass to the incoming sample.
module mic_delay_line #(
    parameter int W     = 16,
    parameter int DEPTH = 32
) (
    input  logic                       clk_in,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   wr_ptr,
    input  logic [$clog2(DEPTH)-1:0]   d,
    input  logic signed [W-1:0]        din,
    output logic signed [W-1:0]        tap
);

    logic signed [W-1:0]      r_mem [DEPTH];
    logic [$clog2(DEPTH)-1:0] w_rd_ptr;

    assign w_rd_ptr = wr_ptr - d;

    always_ff @(posedge clk_in) begin
        if (we) begin
            r_mem[wr_ptr] <= din;
        end
    end

    assign tap = (d == '0) ? din : r_mem[w_rd_ptr];

endmodule

// File: rtl/delay_and_sum_beamformer.sv
// Delay-and-sum beamformer: four delayed mic streams summed into one.
// Owns the write pointer, fill tracking, delay registers and the sum pipeline.
module delay_and_sum_beamformer
    import beamform_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 16,
    parameter int DEPTH        = 32
) (
    input  logic                           clk_in,
    input  logic                           rst_n_in,
    input  logic                           sample_valid_in,
    input  logic signed [SAMPLE_WIDTH-1:0] mic_1_in,
    input  logic signed [SAMPLE_WIDTH-1:0] mic_2_in,
    input  logic signed [SAMPLE_WIDTH-1:0] mic_3_in,
    input  logic signed [SAMPLE_WIDTH-1:0] mic_4_in,
    input  logic [DELAY_W-1:0]             delay_1_in,
    input  logic [DELAY_W-1:0]             delay_2_in,
    input  logic [DELAY_W-1:0]             delay_3_in,
    input  logic [DELAY_W-1:0]             delay_4_in,
    input  logic                           delay_load_in,
    output logic signed [SAMPLE_WIDTH+1:0] sum_out,
    output logic                           sum_valid_out,
    output logic                           busy_out,
    output logic                           delay_err_out
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] MAX_D = PW'(DEPTH - 1);

    logic signed [SAMPLE_WIDTH-1:0] w_mic   [NUM_MICS];
    logic [DELAY_W-1:0]             w_din   [NUM_MICS];
    logic [PW-1:0]                  w_dclmp [NUM_MICS];
    logic signed [SAMPLE_WIDTH-1:0] w_tap   [NUM_MICS];
    logic [NUM_MICS-1:0]            w_over;
    logic [PW-1:0]                  w_dmax;
    logic [PW-1:0]                  w_fill_inc;
    logic                           w_emit;
    logic signed [SAMPLE_WIDTH+1:0] w_sum;
    bf_state_t                      w_state_nxt;

    logic [PW-1:0]                  r_delay [NUM_MICS];
    logic signed [SAMPLE_WIDTH-1:0] r_tap   [NUM_MICS];
    logic [PW-1:0]                  r_wr_ptr;
    logic [PW-1:0]                  r_fill_cnt;
    logic [PW-1:0]                  r_max_d;
    logic                           r_err;
    logic                           r_v1;
    logic                           r_v2;
    logic signed [SAMPLE_WIDTH+1:0] r_sum;
    bf_state_t                      r_state;

    assign w_mic[0] = mic_1_in;
    assign w_mic[1] = mic_2_in;
    assign w_mic[2] = mic_3_in;
    assign w_mic[3] = mic_4_in;
    assign w_din[0] = delay_1_in;
    assign w_din[1] = delay_2_in;
    assign w_din[2] = delay_3_in;
    assign w_din[3] = delay_4_in;

    always_comb begin
        w_over = '0;
        w_dmax = '0;
        for (int k = 0; k < NUM_MICS; k++) begin
            w_over[k]  = w_din[k] > DELAY_W'(DEPTH - 1);
            w_dclmp[k] = w_over[k] ? MAX_D : w_din[k][PW-1:0];
            if (w_dclmp[k] > w_dmax) begin
                w_dmax = w_dclmp[k];
            end
        end
    end

    for (genvar k = 0; k < NUM_MICS; k++) begin : g_mic
        mic_delay_line #(
            .W     (SAMPLE_WIDTH),
            .DEPTH (DEPTH)
        ) u_line (
            .clk_in (clk_in),
            .we     (sample_valid_in),
            .wr_ptr (r_wr_ptr),
            .d      (r_delay[k]),
            .din    (w_mic[k]),
            .tap    (w_tap[k])
        );
    end

    assign w_fill_inc = (r_fill_cnt == MAX_D) ? r_fill_cnt : r_fill_cnt + 1'b1;
    // Emit only once every tap points at a sample written since reset.
    assign w_emit = sample_valid_in && (r_fill_cnt >= r_max_d);

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: if (sample_valid_in)
                      w_state_nxt = (r_max_d == '0) ? RUN : FILL;
            FILL: if (sample_valid_in && (w_fill_inc >= r_max_d))
                      w_state_nxt = RUN;
            RUN:  if (r_max_d > r_fill_cnt)
                      w_state_nxt = FILL;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state    <= IDLE;
            r_wr_ptr   <= '0;
            r_fill_cnt <= '0;
            r_max_d    <= '0;
            r_err      <= 1'b0;
            for (int k = 0; k < NUM_MICS; k++) begin
                r_delay[k] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            if (sample_valid_in) begin
                r_wr_ptr   <= r_wr_ptr + 1'b1;
                r_fill_cnt <= w_fill_inc;
            end
            if (delay_load_in) begin
                r_delay <= w_dclmp;
                r_max_d <= w_dmax;
                if (|w_over) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_sum = '0;
        for (int k = 0; k < NUM_MICS; k++) begin
            w_sum = w_sum + {{2{r_tap[k][SAMPLE_WIDTH-1]}}, r_tap[k]};
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_v1  <= 1'b0;
            r_v2  <= 1'b0;
            r_sum <= '0;
            for (int k = 0; k < NUM_MICS; k++) begin
                r_tap[k] <= '0;
            end
        end else begin
            r_v1 <= w_emit;
            r_v2 <= r_v1;
            if (w_emit) begin
                r_tap <= w_tap;
            end
            if (r_v1) begin
                r_sum <= w_sum;
            end
        end
    end

    assign sum_out       = r_sum;
    assign sum_valid_out = r_v2;
    assign busy_out      = (r_state != RUN);
    assign delay_err_out = r_err;

endmodule

// File: tb/tb_delay_and_sum_beamformer.sv
// Scoreboard bench for delay_and_sum_beamformer against a sample-history model.
// Stimulus pushes expected sums with their due cycle; a monitor pops and compares.
module tb_delay_and_sum_beamformer;

    localparam int SW   = 16;
    localparam int DMAX = 31;

    logic              clk_in = 1'b0;
    logic              rst_n_in = 1'b0;
    logic              sample_valid_in = 1'b0;
    logic signed [SW-1:0] mic_1_in = '0, mic_2_in = '0;
    logic signed [SW-1:0] mic_3_in = '0, mic_4_in = '0;
    logic [7:0]        delay_1_in = '0, delay_2_in = '0;
    logic [7:0]        delay_3_in = '0, delay_4_in = '0;
    logic              delay_load_in = 1'b0;
    logic signed [SW+1:0] sum_out;
    logic              sum_valid_out;
    logic              busy_out;
    logic              delay_err_out;

    delay_and_sum_beamformer #(.SAMPLE_WIDTH(SW), .DEPTH(32)) dut (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .sample_valid_in (sample_valid_in),
        .mic_1_in        (mic_1_in),
        .mic_2_in        (mic_2_in),
        .mic_3_in        (mic_3_in),
        .mic_4_in        (mic_4_in),
        .delay_1_in      (delay_1_in),
        .delay_2_in      (delay_2_in),
        .delay_3_in      (delay_3_in),
        .delay_4_in      (delay_4_in),
        .delay_load_in   (delay_load_in),
        .sum_out         (sum_out),
        .sum_valid_out   (sum_valid_out),
        .busy_out        (busy_out),
        .delay_err_out   (delay_err_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int     sum;
        longint due;
    } exp_t;

    exp_t   sb[$];
    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;

    int     md[4];
    int     hist[4][$];
    bit     merr;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk_in) begin : monitor
        exp_t e;
        while (sb.size() > 0 && sb[0].due < cyc) begin
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_valid: got none expected sum %0d at cycle %0d", e.sum, e.due);
        end
        if (sum_valid_out) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got sum %0d at cycle %0d expected no output",
                         sum_out, cyc);
            end else begin
                e = sb.pop_front();
                check("sum", longint'(sum_out), longint'(e.sum));
                check("latency", cyc, e.due);
            end
        end
    end

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            hist[k].delete();
            md[k] = 0;
        end
        merr = 1'b0;
        sb.delete();
    endtask

    // Tap k is simply the sample delivered md[k] strobes ago.
    task automatic model_strobe(input int m[4]);
        int n, mx, s;
        n = hist[0].size();
        mx = 0;
        for (int k = 0; k < 4; k++) begin
            hist[k].push_back(m[k]);
            if (md[k] > mx) mx = md[k];
        end
        if (n >= mx) begin
            s = 0;
            for (int k = 0; k < 4; k++) s += hist[k][n - md[k]];
            sb.push_back('{s, cyc + 2});
        end
    endtask

    task automatic model_load(input int d[4]);
        for (int k = 0; k < 4; k++) begin
            md[k] = (d[k] > DMAX) ? DMAX : d[k];
            if (d[k] > DMAX) merr = 1'b1;
        end
    endtask

    task automatic step(input bit v, input int m[4], input bit ld, input int d[4]);
        sample_valid_in = v;
        mic_1_in = SW'(m[0]);
        mic_2_in = SW'(m[1]);
        mic_3_in = SW'(m[2]);
        mic_4_in = SW'(m[3]);
        delay_load_in = ld;
        delay_1_in = 8'(d[0]);
        delay_2_in = 8'(d[1]);
        delay_3_in = 8'(d[2]);
        delay_4_in = 8'(d[3]);
        if (v) model_strobe(m);
        if (ld) model_load(d);
        @(posedge clk_in);
        #1;
        sample_valid_in = 1'b0;
        delay_load_in = 1'b0;
    endtask

    task automatic do_reset();
        rst_n_in = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_in);
        #1;
        rst_n_in = 1'b1;
    endtask

    function automatic int rnd_s();
        return int'($urandom_range(65535)) - 32768;
    endfunction

    int m[4], d[4], z[4];

    task automatic rnd_m();
        for (int k = 0; k < 4; k++) m[k] = rnd_s();
    endtask

    initial begin
        z = '{0, 0, 0, 0};
        @(posedge clk_in);
        #1;
        do_reset();
        check("rst_sum", longint'(sum_out), 0);
        check("rst_valid", sum_valid_out, 0);
        check("rst_busy", busy_out, 1);
        check("rst_err", delay_err_out, 0);

        m = '{100, 200, 300, 400};
        step(1, m, 0, z);
        check("busy_after_first", busy_out, 0);
        step(1, m, 0, z);
        step(0, m, 0, z);
        step(1, m, 0, z);
        repeat (3) step(0, z, 0, z);

        do_reset();
        d = '{0, 1, 2, 3};
        step(0, z, 1, d);
        for (int n = 0; n < 8; n++) begin
            m = '{n, n, n, n};
            step(1, m, 0, z);
            if (n == 1) check("busy_fill", busy_out, 1);
        end
        check("busy_run", busy_out, 0);

        d = '{40, 0, 0, 0};
        step(0, z, 1, d);
        step(0, z, 0, z);
        check("err_set", delay_err_out, merr);
        check("busy_refill", busy_out, 1);
        for (int i = 0; i < 40; i++) begin
            rnd_m();
            step(1, m, 0, z);
        end
        d = '{1, 2, 3, 4};
        step(0, z, 1, d);
        check("err_sticky", delay_err_out, merr);
        for (int i = 0; i < 5; i++) begin
            rnd_m();
            step(1, m, 0, z);
        end
        rnd_m();
        step(1, m, 1, z);
        for (int i = 0; i < 5; i++) begin
            rnd_m();
            step(1, m, 0, z);
        end
        check("busy_after_swap", busy_out, 0);
        repeat (3) step(0, z, 0, z);

        do_reset();
        check("err_cleared", delay_err_out, 0);
        d = '{0, 10, 20, 31};
        step(0, z, 1, d);
        for (int i = 0; i < 40; i++) begin
            rnd_m();
            step(1, m, 0, z);
        end
        step(0, z, 1, z);
        rnd_m();
        step(1, m, 0, z);
        rnd_m();
        step(1, m, 0, z);
        rst_n_in = 1'b0;
        model_reset();
        #1;
        check("midrst_valid", sum_valid_out, 0);
        check("midrst_sum", longint'(sum_out), 0);
        check("midrst_busy", busy_out, 1);
        @(posedge clk_in);
        #1;
        rst_n_in = 1'b1;
        repeat (4) step(0, z, 0, z);
        d = '{0, 0, 0, 5};
        step(0, z, 1, d);
        for (int i = 0; i < 10; i++) begin
            rnd_m();
            step(1, m, 0, z);
        end

        for (int i = 0; i < 400; i++) begin
            rnd_m();
            for (int k = 0; k < 4; k++)
                d[k] = ($urandom_range(9) == 0) ? 40 : int'($urandom_range(24));
            step($urandom_range(3) != 0, m, $urandom_range(24) == 0, d);
        end
        repeat (4) step(0, z, 0, z);
        check("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
